simple_split_2: RTL and testbench
=================================

Name: simple_split_2

Overview:
- Receive-side counterpart of the two-lane bitwise combiner blocks used in the flatten regression set.
- Accepts a single stream of WIDTH-bit words on a valid/ready handshake and distributes words alternately to two output lanes, out1 and out2.
- Each output lane is buffered by its own DEPTH-entry FIFO with valid/ready handshake.
- Serves as a sequential, multi-instance regression target for hierarchy flattening: two FIFO sub-instances plus a steering FSM.

Parameters:
- WIDTH, 6, data word width of input and both output lanes.
- DEPTH, 4, entries per lane FIFO; power of two, minimum 2.
- CW, 8, width of the accepted-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in1_valid  input  1  input word valid.
- in1_ready  output  1  input word accepted this cycle when high with in1_valid.
- in1  input  WIDTH  input word.
- lock1  input  1  when high, all accepted words go to lane 1; alternation suspended.
- out1_valid  output  1  lane 1 head word valid.
- out1_ready  input  1  lane 1 consumer ready.
- out1  output  WIDTH  lane 1 head word.
- out2_valid  output  1  lane 2 head word valid.
- out2_ready  input  1  lane 2 consumer ready.
- out2  output  WIDTH  lane 2 head word.
- sel  output  1  lane targeted by the next accepted word (0 = lane 1, 1 = lane 2).
- word_cnt  output  CW  total accepted words, wraps modulo 2^CW.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- While rst is high: all FIFO pointers and counts are 0; out1_valid = out2_valid = 0; sel = 0; word_cnt = 0. in1_ready is 0 during reset.
- Reset asserted mid-operation: buffered words are discarded immediately, with no handshake completion.
- Steering FSM has two states:
  - LANE1 (sel = 0) and LANE2 (sel = 1).
  - On accept (in1_valid & in1_ready) with lock1 = 0: toggle state.
  - On accept with lock1 = 1: force next state to LANE1.
  - With lock1 = 1, the effective target is lane 1 regardless of sel.
  - No accept: state holds.
- in1_ready = NOT full(target lane FIFO). It never depends on the non-target lane.
- Full-lane push is blocked even if that lane is popped in the same cycle; there is no pass-through when full.
- Lane FIFO behaviour:
  - First-word fall-through.
  - A word accepted at edge N appears as the head at output from edge N, i.e. out_valid rises the cycle after accept. Latency is 1 cycle.
  - outX_valid = count != 0; outX shows the head entry.
  - Pop on outX_valid & outX_ready.
  - Write/read pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0. count is log2(DEPTH)+1 bits, range 0..DEPTH.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pop when empty: ignored.
  - outX holds its value while valid and not ready (stable under backpressure).
- word_cnt increments by 1 per accept and wraps from 2^CW-1 to 0.
- Ordering: within each lane, words are output in acceptance order. No word is ever dropped or duplicated.

Test Plan:
- Reset, then in1_valid = 1 with words 0x01..0x06 on consecutive cycles; both ready = 1 -> out1 sees 0x01, 0x03, 0x05; out2 sees 0x02, 0x04, 0x06; each word valid 1 cycle after accept; word_cnt = 6.
- out1_ready = 0, out2_ready = 1, stream 10 words -> lane 1 fills to 4 (words 1, 3, 5, 7); in1_ready drops when sel = 0 with the 9th word pending; out1 holds 0x01 stable. Raising out1_ready releases 1, 3, 5, 7, 9 in order.
- lock1 = 1, stream 0x2A, 0x15, 0x3F -> all three appear on out1 and none on out2; after release, the next word goes to lane 2 only if sel toggles from LANE1 on the following accept (first post-lock word goes to lane 1).
- Lane 1 full and out1_ready = 1 with a lane-1 push offered in the same cycle -> push refused (in1_ready = 0), count goes 4 -> 3, next cycle push accepted.
- Load 3 words, assert rst asynchronously mid-cycle -> out1_valid/out2_valid drop immediately; sel = 0 and word_cnt = 0; the post-reset first word goes to lane 1.
- Accept 257 words with CW = 8 -> word_cnt reads 1; FIFO pointer wrap verified by DEPTH + 2 words through each lane with correct order.

Source files
------------

// File: rtl/simple_split_2.sv
// simple_split_2: one valid/ready input stream split into two buffered lanes.
// Accepted words alternate between lane 1 and lane 2 unless lock1 pins
// them all to lane 1. Each lane has its own first-word-fall-through FIFO.

module simple_split_2_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A full lane refuses a push even when it is popped in the same cycle,
  // so the input-side ready never depends on the consumer's ready.
  assign full    = (count == (AW+1)'(DEPTH));
  assign valid   = (count != '0);
  assign do_push = push & ~full;
  assign do_pop  = pop_ready & valid;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  // NOTE: the data array has no reset; valid is derived from count, so
  // stale entries are never visible and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

module simple_split_2 #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic             lock1,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2,
  output logic             sel,
  output logic [CW-1:0]    word_cnt
);

  typedef enum logic {
    LANE1 = 1'b0,
    LANE2 = 1'b1
  } lane_t;

  lane_t state;
  lane_t target;
  logic  full1;
  logic  full2;
  logic  target_full;
  logic  accept;

  // Lock overrides the steering state; only the target lane gates ready.
  assign target      = lock1 ? LANE1 : state;
  assign target_full = (target == LANE1) ? full1 : full2;
  assign in1_ready   = ~rst & ~target_full;
  assign accept      = in1_valid & in1_ready;
  assign sel         = state;

  // Steering FSM: toggle on each unlocked accept, fall back to LANE1 when locked.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LANE1;
    end else if (accept) begin
      if (lock1) state <= LANE1;
      else       state <= (state == LANE1) ? LANE2 : LANE1;
    end
  end

  // Accepted-word counter, wraps modulo 2^CW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         word_cnt <= '0;
    else if (accept) word_cnt <= word_cnt + 1'b1;
  end

  simple_split_2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
    .clk       (clk),
    .rst       (rst),
    .push      (accept && (target == LANE1)),
    .push_data (in1),
    .pop_ready (out1_ready),
    .full      (full1),
    .valid     (out1_valid),
    .head      (out1)
  );

  simple_split_2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane2 (
    .clk       (clk),
    .rst       (rst),
    .push      (accept && (target == LANE2)),
    .push_data (in1),
    .pop_ready (out2_ready),
    .full      (full2),
    .valid     (out2_valid),
    .head      (out2)
  );

endmodule

// File: tb/tb_simple_split_2.sv
// Bench for simple_split_2: queue-based lane model plus scenario tasks.
module tb_simple_split_2;

  localparam int WIDTH = 6;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in1_valid;
  logic             in1_ready;
  logic [WIDTH-1:0] in1;
  logic             lock1;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1;
  logic             out2_valid;
  logic             out2_ready;
  logic [WIDTH-1:0] out2;
  logic             sel;
  logic [CW-1:0]    word_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one queue per lane, the next-target lane and a counter.
  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] q2[$];
  logic             m_sel;
  logic [CW-1:0]    m_cnt;

  // Words actually handed to each consumer, in order.
  logic [WIDTH-1:0] log1[$];
  logic [WIDTH-1:0] log2[$];

  always #5 clk = ~clk;

  simple_split_2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in1_valid  (in1_valid),
    .in1_ready  (in1_ready),
    .in1        (in1),
    .lock1      (lock1),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1       (out1),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .out2       (out2),
    .sel        (sel),
    .word_cnt   (word_cnt)
  );

  task automatic model_clear();
    q1.delete(); q2.delete(); log1.delete(); log2.delete();
    m_sel = 1'b0;
    m_cnt = '0;
  endtask

  // Drive one clock of stimulus, compare every output with the model just
  // before the edge, then advance the model across the edge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic lk,
                       input logic r1, input logic r2, output logic acc);
    logic tgt2;
    logic e_ready;
    logic p1, p2;
    @(negedge clk);
    in1_valid = v; in1 = d; lock1 = lk; out1_ready = r1; out2_ready = r2;
    #1;
    tgt2    = lk ? 1'b0 : m_sel;
    e_ready = tgt2 ? (q2.size() != DEPTH) : (q1.size() != DEPTH);
    n_cmp++;
    if (in1_ready !== e_ready) begin
      n_bad++; $display("FAIL in1_ready: got %b want %b", in1_ready, e_ready);
    end
    n_cmp++;
    if (out1_valid !== (q1.size() != 0)) begin
      n_bad++; $display("FAIL out1_valid: got %b want %b", out1_valid, q1.size() != 0);
    end
    n_cmp++;
    if (out2_valid !== (q2.size() != 0)) begin
      n_bad++; $display("FAIL out2_valid: got %b want %b", out2_valid, q2.size() != 0);
    end
    if (q1.size() != 0) begin
      n_cmp++;
      if (out1 !== q1[0]) begin
        n_bad++; $display("FAIL out1 data: got %h want %h", out1, q1[0]);
      end
    end
    if (q2.size() != 0) begin
      n_cmp++;
      if (out2 !== q2[0]) begin
        n_bad++; $display("FAIL out2 data: got %h want %h", out2, q2[0]);
      end
    end
    n_cmp++;
    if (sel !== m_sel) begin
      n_bad++; $display("FAIL sel: got %b want %b", sel, m_sel);
    end
    n_cmp++;
    if (word_cnt !== m_cnt) begin
      n_bad++; $display("FAIL word_cnt: got %0d want %0d", word_cnt, m_cnt);
    end
    if (r1 && out1_valid) log1.push_back(out1);
    if (r2 && out2_valid) log2.push_back(out2);
    acc = v && e_ready;
    p1  = r1 && (q1.size() != 0);
    p2  = r2 && (q2.size() != 0);
    @(posedge clk);
    if (p1) void'(q1.pop_front());
    if (p2) void'(q2.pop_front());
    if (acc) begin
      if (tgt2) q2.push_back(d);
      else      q1.push_back(d);
      m_cnt = m_cnt + 1'b1;
      m_sel = lk ? 1'b0 : ~m_sel;
    end
  endtask

  task automatic drain(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    in1_valid = 1'b0; in1 = '0; lock1 = 1'b0; out1_ready = 1'b0; out2_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    in1_valid = 1'b1; in1 = 6'h11; lock1 = 1'b0; out1_ready = 1'b1; out2_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in1_ready, out1_valid, out2_valid, sel} !== 4'b0000 || word_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset state: got ready=%b v1=%b v2=%b sel=%b cnt=%0d want all 0",
               in1_ready, out1_valid, out2_valid, sel, word_cnt);
    end
    rst = 1'b0;
    in1_valid = 1'b0;
    model_clear();
  endtask

  task automatic test_alternate();
    logic acc;
    apply_reset();
    for (int w = 1; w <= 6; w++) cycle(1'b1, WIDTH'(w), 1'b0, 1'b1, 1'b1, acc);
    drain(3);
    n_cmp++;
    if (word_cnt !== CW'(6)) begin
      n_bad++; $display("FAIL alt word_cnt: got %0d want 6", word_cnt);
    end
    n_cmp++;
    if (log1 != '{6'h01, 6'h03, 6'h05} || log2 != '{6'h02, 6'h04, 6'h06}) begin
      n_bad++; $display("FAIL alt order: got lane1=%p lane2=%p want 1,3,5 / 2,4,6", log1, log2);
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    int   w;
    apply_reset();
    w = 1;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, WIDTH'(w), 1'b0, 1'b0, 1'b1, acc);
      if (acc && w < 10) w++;
    end
    n_cmp++;
    if (w !== 9) begin
      n_bad++; $display("FAIL bp accepted: got next word %0d want 9", w);
    end
    #1;
    n_cmp++;
    if (in1_ready !== 1'b0 || sel !== 1'b0 || out1 !== 6'h01 || out1_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp stall: got ready=%b sel=%b out1=%h v1=%b want 0,0,01,1",
                        in1_ready, sel, out1, out1_valid);
    end
    for (int i = 0; i < 16 && w <= 10; i++) begin
      cycle(1'b1, WIDTH'(w), 1'b0, 1'b1, 1'b1, acc);
      if (acc) w++;
    end
    drain(6);
    n_cmp++;
    if (log1 != '{6'h01, 6'h03, 6'h05, 6'h07, 6'h09} ||
        log2 != '{6'h02, 6'h04, 6'h06, 6'h08, 6'h0A}) begin
      n_bad++; $display("FAIL bp order: got lane1=%p lane2=%p", log1, log2);
    end
  endtask

  task automatic test_lock();
    logic acc;
    apply_reset();
    cycle(1'b1, 6'h2A, 1'b1, 1'b1, 1'b1, acc);
    cycle(1'b1, 6'h15, 1'b1, 1'b1, 1'b1, acc);
    cycle(1'b1, 6'h3F, 1'b1, 1'b1, 1'b1, acc);
    cycle(1'b1, 6'h01, 1'b0, 1'b1, 1'b1, acc);
    cycle(1'b1, 6'h02, 1'b0, 1'b1, 1'b1, acc);
    drain(3);
    n_cmp++;
    if (log1 != '{6'h2A, 6'h15, 6'h3F, 6'h01} || log2 != '{6'h02}) begin
      n_bad++; $display("FAIL lock order: got lane1=%p lane2=%p want 2a,15,3f,01 / 02", log1, log2);
    end
  endtask

  task automatic test_full_pop();
    logic acc;
    int   w;
    apply_reset();
    w = 1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, WIDTH'(w), 1'b0, 1'b0, 1'b1, acc);
      if (acc) w++;
    end
    cycle(1'b1, 6'h09, 1'b0, 1'b1, 1'b1, acc);
    n_cmp++;
    if (acc !== 1'b0) begin
      n_bad++; $display("FAIL full pop push: got accept=%b want 0", acc);
    end
    cycle(1'b1, 6'h09, 1'b0, 1'b0, 1'b1, acc);
    n_cmp++;
    if (acc !== 1'b1) begin
      n_bad++; $display("FAIL full pop retry: got accept=%b want 1", acc);
    end
    drain(6);
    n_cmp++;
    if (log1 != '{6'h01, 6'h03, 6'h05, 6'h07, 6'h09}) begin
      n_bad++; $display("FAIL full pop order: got lane1=%p", log1);
    end
  endtask

  task automatic test_async_reset();
    logic acc;
    apply_reset();
    for (int w = 1; w <= 3; w++) cycle(1'b1, WIDTH'(w), 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    in1_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out1_valid, out2_valid, sel, in1_ready} !== 4'b0000 || word_cnt !== '0) begin
      n_bad++;
      $display("FAIL async reset: got v1=%b v2=%b sel=%b ready=%b cnt=%0d want all 0",
               out1_valid, out2_valid, sel, in1_ready, word_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    cycle(1'b1, 6'h2C, 1'b0, 1'b1, 1'b1, acc);
    drain(2);
    n_cmp++;
    if (log1 != '{6'h2C} || log2.size() != 0) begin
      n_bad++; $display("FAIL post reset: got lane1=%p lane2=%p want 2c / none", log1, log2);
    end
  endtask

  task automatic test_wrap();
    logic acc;
    int   bad;
    apply_reset();
    for (int i = 0; i < 257; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b1, 1'b1, acc);
    drain(3);
    n_cmp++;
    if (word_cnt !== CW'(1)) begin
      n_bad++; $display("FAIL wrap word_cnt: got %0d want 1", word_cnt);
    end
    bad = 0;
    if (log1.size() != 129 || log2.size() != 128) bad = 1;
    else begin
      for (int k = 0; k < 129; k++) if (log1[k] !== WIDTH'(2 * k)) bad = 1;
      for (int k = 0; k < 128; k++) if (log2[k] !== WIDTH'(2 * k + 1)) bad = 1;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL wrap order: got sizes %0d/%0d want 129/128 in order",
                        log1.size(), log2.size());
    end
  endtask

  task automatic test_random();
    logic acc;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), WIDTH'($urandom),
            1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), acc);
    end
    drain(10);
    n_cmp++;
    if (q1.size() != 0 || q2.size() != 0 || out1_valid !== 1'b0 || out2_valid !== 1'b0) begin
      n_bad++; $display("FAIL random drain: got v1=%b v2=%b want both empty", out1_valid, out2_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    in1_valid = 1'b0; in1 = '0; lock1 = 1'b0; out1_ready = 1'b0; out2_ready = 1'b0;
    model_clear();
    test_reset();
    test_alternate();
    test_backpressure();
    test_lock();
    test_full_pop();
    test_async_reset();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
